// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, byte-lane stores, raw word loads.
// Ports: clk/rst, req_* handshake in, resp_* handshake out with rdata/err.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        enter_resp;
  logic [31:0] off;
  logic        mis, ill, oor, err;
  logic [IW-1:0] idx;
  logic [3:0]  be;
  logic [31:0] wlane;

  // Extension is the core's job; the sign bit of funct3 is not needed here.
  logic unused_f3;
  assign unused_f3 = req_funct3[2];

  assign req_ready  = (state_q == IDLE) && !rst;
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // BUSY always lasts WAIT_STATES+1 cycles, so the response
  // appears WAIT_STATES+1 edges after the accepting edge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BUSY;
          cnt_d   = 4'(WAIT_STATES);
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign off = addr_q - BASE_ADDR;
  assign idx = off[IW+1:2];
  assign ill = (size_q == 2'b11);
  assign mis = ((size_q == 2'b01) && addr_q[0]) ||
               ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
  assign oor = (off[31:2] >= 30'(DEPTH_WORDS));
  assign err = ill || mis || oor;

  always_comb begin
    be    = 4'b0000;
    wlane = wdata_q;
    unique case (size_q)
      2'b00: begin
        be    = 4'b0001 << addr_q[1:0];
        wlane = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << addr_q[1:0];
        wlane = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        be    = 4'b1111;
        wlane = wdata_q;
      end
      default: begin
        be    = 4'b0000;
        wlane = wdata_q;
      end
    endcase
  end

  // RAM is never reset; a reset edge also blocks a pending commit.
  always_ff @(posedge clk) begin
    if (enter_resp && we_q && !err && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        size_q  <= req_funct3[1:0];
      end
      if (enter_resp) begin
        err_q   <= err;
        rdata_q <= (err || we_q) ? 32'd0 : mem[idx];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder
// (DEPTH_WORDS=256, WAIT_STATES=1, BASE_ADDR=0).
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int vectors;
  int miscompares;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_X  = 3'b011;
  localparam logic [2:0] F_BU = 3'b100;

  dmem_responder #(
    .DEPTH_WORDS(256),
    .WAIT_STATES(1),
    .BASE_ADDR(32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_funct3(req_funct3),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xact(input logic we,
                      input logic [31:0] a,
                      input logic [31:0] wd,
                      input logic [2:0] f3,
                      input int hold,
                      output logic [31:0] rd,
                      output logic er,
                      output int lat);
    int n;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = a;
    req_wdata  = wd;
    req_funct3 = f3;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rd = resp_rdata;
    er = resp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_rdata", resp_rdata, rd);
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic op(input string tag,
                    input logic we,
                    input logic [31:0] a,
                    input logic [31:0] wd,
                    input logic [2:0] f3,
                    input logic [31:0] exp_rd,
                    input logic exp_er);
    logic [31:0] rd;
    logic er;
    int lat;
    xact(we, a, wd, f3, 0, rd, er, lat);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, 32'(er), 32'(exp_er));
    chk({tag, "_lat"}, 32'(lat), 32'd2);
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    int lat;
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_we      = 1'b0;
    req_addr    = 32'd0;
    req_wdata   = 32'd0;
    req_funct3  = 3'd0;
    resp_ready  = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    op("sw10", 1'b1, 32'h10, 32'hDEADBEEF, F_W, 32'h0, 1'b0);
    chk("idle_ready", 32'(req_ready), 32'd1);
    chk("idle_valid", 32'(resp_valid), 32'd0);
    op("lw10", 1'b0, 32'h10, 32'h0, F_W, 32'hDEADBEEF, 1'b0);

    op("sw10b", 1'b1, 32'h10, 32'h11223344, F_W, 32'h0, 1'b0);
    op("sb13", 1'b1, 32'h13, 32'h000000AA, F_B, 32'h0, 1'b0);
    op("lw10b", 1'b0, 32'h10, 32'h0, F_W, 32'hAA223344, 1'b0);

    op("sh12", 1'b1, 32'h12, 32'h0000BEEF, F_H, 32'h0, 1'b0);
    op("lw10c", 1'b0, 32'h10, 32'h0, F_W, 32'hBEEF3344, 1'b0);
    op("sh11", 1'b1, 32'h11, 32'h00001234, F_H, 32'h0, 1'b1);
    op("lw10d", 1'b0, 32'h10, 32'h0, F_W, 32'hBEEF3344, 1'b0);
    op("lbu11", 1'b0, 32'h11, 32'h0, F_BU, 32'hBEEF3344, 1'b0);
    op("lh12", 1'b0, 32'h12, 32'h0, F_H, 32'hBEEF3344, 1'b0);
    op("lw12", 1'b0, 32'h12, 32'h0, F_W, 32'h0, 1'b1);
    op("sb11", 1'b1, 32'h11, 32'h00000077, F_B, 32'h0, 1'b0);
    op("lw10e", 1'b0, 32'h10, 32'h0, F_W, 32'hBEEF7744, 1'b0);

    op("sw3fc", 1'b1, 32'h3FC, 32'hCAFEF00D, F_W, 32'h0, 1'b0);
    op("lw3fc", 1'b0, 32'h3FC, 32'h0, F_W, 32'hCAFEF00D, 1'b0);
    op("sw0", 1'b1, 32'h0, 32'h01020304, F_W, 32'h0, 1'b0);
    op("sw400", 1'b1, 32'h400, 32'hFFFFFFFF, F_W, 32'h0, 1'b1);
    op("lw0", 1'b0, 32'h0, 32'h0, F_W, 32'h01020304, 1'b0);
    op("lw400", 1'b0, 32'h400, 32'h0, F_W, 32'h0, 1'b1);
    op("f011", 1'b0, 32'h10, 32'h0, F_X, 32'h0, 1'b1);

    xact(1'b0, 32'h10, 32'h0, F_W, 5, rd, er, lat);
    chk("hold_rd", rd, 32'hBEEF7744);
    chk("hold_lat", 32'(lat), 32'd2);
    chk("hold_after", 32'(req_ready), 32'd1);

    op("sw20", 1'b1, 32'h20, 32'h55667788, F_W, 32'h0, 1'b0);
    op("lw20", 1'b0, 32'h20, 32'h0, F_W, 32'h55667788, 1'b0);

    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_addr   = 32'h20;
    req_wdata  = 32'h12345678;
    req_funct3 = F_W;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_rdata", resp_rdata, 32'd0);
    chk("mid_rst_err", 32'(resp_err), 32'd0);
    @(posedge clk);
    #1;
    chk("mid_rst_valid2", 32'(resp_valid), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_ready2", 32'(req_ready), 32'd1);
    op("lw20b", 1'b0, 32'h20, 32'h0, F_W, 32'h55667788, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
